// File: rtl/consumer.sv
// Read-side controller of a dual-clock FIFO: write-pointer synchronizer, read pointers,
// memory read strobe and a 2-entry FWFT output buffer. Define CONSUMER_ALMOST_EMPTY_EN for almost_empty.
module consumer #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned AE_LEVEL   = 4
) (
  input  logic                  clk,
  input  logic                  r_rst,
  input  logic [ADDR_WIDTH:0]   Gray_wptr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  r_mem_en,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   gray_rptr,
  output logic [ADDR_WIDTH:0]   binary_rptr,
  output logic [ADDR_WIDTH:0]   rd_level,
  output logic                  almost_empty
);

  localparam int unsigned PW = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } buf_state_e;

  logic [PW-1:0]         r_sync1, r_wptr_sync, w_wptr_bin;
  logic [PW-1:0]         r_bin_rptr, r_gray_rptr, w_bin_rptr_nxt, w_gray_rptr_nxt;
  logic                  r_empty, r_inflight, w_pop, w_mem_en;
  logic [1:0]            w_occ;
  buf_state_e            r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_buf0, r_buf1, w_buf0_nxt, w_buf1_nxt;

  always_comb begin
    w_wptr_bin = '0;
    for (int i = 0; i < int'(PW); i++) begin
      w_wptr_bin[i] = ^(r_wptr_sync >> i);
    end
  end

  assign w_pop = dout_valid & dout_ready;
  // Occupancy after this cycle's pop; pop implies buf_cnt >= 1, so no underflow.
  assign w_occ = r_state + {1'b0, r_inflight} - {1'b0, w_pop};
  assign w_mem_en = !r_empty && (w_occ < 2'd2);

  assign w_bin_rptr_nxt  = r_bin_rptr + PW'(w_mem_en);
  assign w_gray_rptr_nxt = (w_bin_rptr_nxt >> 1) ^ w_bin_rptr_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_buf0_nxt  = r_buf0;
    w_buf1_nxt  = r_buf1;
    case (r_state)
      StEmpty: begin
        if (r_inflight) begin
          w_buf0_nxt  = mem_rdata;
          w_state_nxt = StOne;
        end
      end
      StOne: begin
        if (r_inflight && w_pop) begin
          w_buf0_nxt = mem_rdata;
        end else if (r_inflight) begin
          w_buf1_nxt  = mem_rdata;
          w_state_nxt = StTwo;
        end else if (w_pop) begin
          w_state_nxt = StEmpty;
        end
      end
      StTwo: begin
        if (w_pop) begin
          w_buf0_nxt = r_buf1;
          if (r_inflight) begin
            w_buf1_nxt = mem_rdata;
          end else begin
            w_state_nxt = StOne;
          end
        end
      end
      default: w_state_nxt = StEmpty;
    endcase
  end

  always_ff @(posedge clk) begin
    if (r_rst) begin
      r_sync1     <= '0;
      r_wptr_sync <= '0;
      r_bin_rptr  <= '0;
      r_gray_rptr <= '0;
      r_empty     <= 1'b1;
      r_inflight  <= 1'b0;
      r_state     <= StEmpty;
      r_buf0      <= '0;
      r_buf1      <= '0;
    end else begin
      r_sync1     <= Gray_wptr;
      r_wptr_sync <= r_sync1;
      r_bin_rptr  <= w_bin_rptr_nxt;
      r_gray_rptr <= w_gray_rptr_nxt;
      r_empty     <= (w_gray_rptr_nxt == r_wptr_sync);
      r_inflight  <= w_mem_en;
      r_state     <= w_state_nxt;
      r_buf0      <= w_buf0_nxt;
      r_buf1      <= w_buf1_nxt;
    end
  end

`ifdef CONSUMER_ALMOST_EMPTY_EN
  logic          r_almost_empty;
  logic [PW-1:0] w_rd_level_nxt;

  assign w_rd_level_nxt = w_wptr_bin - w_bin_rptr_nxt;

  always_ff @(posedge clk) begin
    if (r_rst) begin
      r_almost_empty <= 1'b1;
    end else begin
      r_almost_empty <= (w_rd_level_nxt <= PW'(AE_LEVEL));
    end
  end

  assign almost_empty = r_almost_empty;
`else
  assign almost_empty = 1'b0;
`endif

  assign r_addr      = r_bin_rptr[ADDR_WIDTH-1:0];
  assign r_mem_en    = w_mem_en;
  assign dout        = r_buf0;
  assign dout_valid  = (r_state != StEmpty);
  assign empty       = r_empty;
  assign gray_rptr   = r_gray_rptr;
  assign binary_rptr = r_bin_rptr;
  assign rd_level    = w_wptr_bin - r_bin_rptr;

endmodule

// File: tb/tb_consumer.sv
// Directed bench for consumer: memory model, write-pointer driver and an in-order
// scoreboard of words expected at dout. Honours CONSUMER_ALMOST_EMPTY_EN.
module tb_consumer;

  localparam int AW    = 9;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          r_rst;
  logic [AW:0]   Gray_wptr;
  logic [AW-1:0] r_addr;
  logic          r_mem_en;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          empty;
  logic [AW:0]   gray_rptr;
  logic [AW:0]   binary_rptr;
  logic [AW:0]   rd_level;
  logic          almost_empty;

  always #5 clk = ~clk;

  consumer #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .AE_LEVEL  (4)
  ) dut (
    .clk         (clk),
    .r_rst       (r_rst),
    .Gray_wptr   (Gray_wptr),
    .r_addr      (r_addr),
    .r_mem_en    (r_mem_en),
    .mem_rdata   (mem_rdata),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .empty       (empty),
    .gray_rptr   (gray_rptr),
    .binary_rptr (binary_rptr),
    .rd_level    (rd_level),
    .almost_empty(almost_empty)
  );

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] q [$];
  logic [AW:0]   wptr;
  int n_chk = 0, n_fail = 0, en_cnt = 0, pop_cnt = 0;
  int en0, p0, k, n, exp_ptr;
  bit mon_on = 1'b0;

  // Synchronous-read memory: data valid the cycle after r_mem_en.
  always @(posedge clk) begin
    if (r_mem_en === 1'b1) mem_rdata <= mem[r_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on && r_rst === 1'b0) begin
      if (r_mem_en === 1'b1) en_cnt++;
      chk("occupancy_le_2", 32'(int'(dut.r_state) + int'(dut.r_inflight) <= 2), 1);
      if (dout_valid === 1'b1 && dout_ready === 1'b1) begin
        pop_cnt++;
        chk("sb_has_entry", 32'(q.size() != 0), 1);
        if (q.size() != 0) chk("dout_order", 32'(dout), 32'(q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_gray();
    Gray_wptr = wptr ^ (wptr >> 1);
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    mem[wptr[AW-1:0]] = d;
    q.push_back(d);
    wptr = wptr + 1'b1;
  endtask

  task automatic send_rand(input int cnt);
    for (int i = 0; i < cnt; i++) push_word(DW'($urandom_range(0, 255)));
  endtask

  task automatic sys_reset();
    r_rst = 1'b1;
    wptr = '0;
    Gray_wptr = '0;
    q.delete();
    tick();
    r_rst = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (!(q.size() == 0 && empty === 1'b1 && dout_valid === 1'b0) && w < 3000) begin
      tick();
      w++;
    end
    chk("drain_in_time", 32'(w < 3000), 1);
  endtask

  task automatic wait_en(input string tag);
    int w;
    w = 0;
    while (r_mem_en !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    chk(tag, 32'(r_mem_en), 1);
  endtask

  initial begin
    foreach (mem[i]) mem[i] = '0;
    r_rst = 1'b1;
    Gray_wptr = '0;
    wptr = '0;
    dout_ready = 1'b0;

    // 1: reset
    repeat (2) tick();
    mon_on = 1'b1;
    r_rst = 1'b0;
    tick();
    chk("rst_empty", 32'(empty), 1);
    chk("rst_dout_valid", 32'(dout_valid), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_mem_en", 32'(r_mem_en), 0);
    chk("rst_binary_rptr", 32'(binary_rptr), 0);
    chk("rst_gray_rptr", 32'(gray_rptr), 0);
    chk("rst_rd_level", 32'(rd_level), 0);
`ifdef CONSUMER_ALMOST_EMPTY_EN
    chk("rst_almost_empty", 32'(almost_empty), 1);
`else
    chk("rst_almost_empty", 32'(almost_empty), 0);
`endif

    // 2: single word, latency and hold under backpressure
    push_word(8'hA5);
    set_gray();
    tick();
    chk("e1_empty", 32'(empty), 1);
    tick();
    chk("e2_empty", 32'(empty), 1);
    tick();
    chk("e3_empty", 32'(empty), 0);
    chk("e3_mem_en", 32'(r_mem_en), 1);
    chk("e3_addr", 32'(r_addr), 0);
    tick();
    chk("e4_binary_rptr", 32'(binary_rptr), 1);
    chk("e4_gray_rptr", 32'(gray_rptr), 1);
    chk("e4_mem_en", 32'(r_mem_en), 0);
    chk("e4_dout_valid", 32'(dout_valid), 0);
    tick();
    chk("e5_dout_valid", 32'(dout_valid), 1);
    chk("e5_dout", 32'(dout), 32'h A5);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_valid", 32'(dout_valid), 1);
      chk("hold_dout", 32'(dout), 32'h A5);
    end
    dout_ready = 1'b1;
    tick();
    chk("pop_dout_valid", 32'(dout_valid), 0);
    chk("pop_empty", 32'(empty), 1);
    chk("pop_gray_rptr", 32'(gray_rptr), 1);

    // 3: streaming 16 words at full rate
    sys_reset();
    p0 = pop_cnt;
    dout_ready = 1'b1;
    send_rand(16);
    set_gray();
    wait_en("stream_start");
    for (int i = 0; i < 16; i++) begin
      chk("stream_mem_en", 32'(r_mem_en), 1);
      chk("stream_addr", 32'(r_addr), 32'(i));
      tick();
    end
    chk("stream_stop", 32'(r_mem_en), 0);
    drain();
    chk("stream_binary_rptr", 32'(binary_rptr), 16);
    chk("stream_gray_rptr", 32'(gray_rptr), 32'h18);
    chk("stream_empty", 32'(empty), 1);
    chk("stream_pops", 32'(pop_cnt - p0), 16);

    // 4: backpressure then release
    dout_ready = 1'b0;
    en0 = en_cnt;
    send_rand(8);
    set_gray();
    repeat (12) tick();
    chk("bp_reads", 32'(en_cnt - en0), 2);
    chk("bp_dout_valid", 32'(dout_valid), 1);
    chk("bp_rd_level", 32'(rd_level), 6);
`ifdef CONSUMER_ALMOST_EMPTY_EN
    chk("bp_almost_empty", 32'(almost_empty), 0);
`endif
    p0 = pop_cnt;
    dout_ready = 1'b1;
    repeat (8) tick();
    chk("bp_release_pops", 32'(pop_cnt - p0), 8);
    chk("bp_sb_empty", 32'(q.size()), 0);
    drain();

    // 5: advance both sides to 1022, then wrap the address and the pointer
    while (wptr != (AW + 1)'(1022)) begin
      n = 1022 - int'(wptr);
      if (n > 256) n = 256;
      send_rand(n);
      set_gray();
      drain();
    end
    chk("wrap_pre_rptr", 32'(binary_rptr), 1022);
    send_rand(4);
    set_gray();
    wait_en("wrap_start");
    for (int i = 0; i < 4; i++) begin
      chk("wrap_mem_en", 32'(r_mem_en), 1);
      chk("wrap_addr", 32'(r_addr), 32'((1022 + i) % DEPTH));
      tick();
    end
    chk("wrap_stop", 32'(r_mem_en), 0);
    drain();
    exp_ptr = 1026 % (2 * DEPTH);
    chk("wrap_binary_rptr", 32'(binary_rptr), 32'(exp_ptr));
    chk("wrap_gray_rptr", 32'(gray_rptr), 32'(exp_ptr ^ (exp_ptr >> 1)));
    chk("wrap_empty", 32'(empty), 1);

    // 6: reset with one word buffered and one read in flight
    dout_ready = 1'b0;
    send_rand(4);
    set_gray();
    k = 0;
    while (!(int'(dut.r_state) == 1 && dut.r_inflight === 1'b1) && k < 20) begin
      tick();
      k++;
    end
    chk("mid_state_reached", 32'(k < 20), 1);
    sys_reset();
    chk("mid_dout_valid", 32'(dout_valid), 0);
    chk("mid_empty", 32'(empty), 1);
    chk("mid_binary_rptr", 32'(binary_rptr), 0);
    chk("mid_gray_rptr", 32'(gray_rptr), 0);
    chk("mid_rd_level", 32'(rd_level), 0);
    en0 = en_cnt;
    repeat (10) tick();
    chk("mid_no_reads", 32'(en_cnt - en0), 0);
    chk("mid_still_idle", 32'(dout_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
